generador_trafico: RTL and testbench

Synthesizable, parametrised traffic generator and self-checker for the interconnect device. It drives the device's input port (`data_in`/`push_data_in`) and honours `MAIN_FIFO_pause`. It drains every output FIFO through `pop[i]`/`next_pop[i]` and checks each returned word against the expected per-output sequence. It replaces open-loop bench stimulus, and can run on-chip or in simulation against any channel count.

---
 rtl/gen_trafico_pkg.sv | 23 ++
 rtl/checker_salida.sv | 44 ++++
 rtl/generador_trafico.sv | 169 ++++++++++++++++
 tb/tb_generador_trafico.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gen_trafico_pkg.sv
// Shared state encoding, mode constants and helpers for the traffic generator.
package gen_trafico_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONFIG,
    SEND,
    DRAIN,
    DONE
  } state_t;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
  localparam int   ERR_CNT_W  = 8;

  function automatic int unsigned count_ones(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int k = 0; k < 32; k++) n = n + 32'(v[k]);
    return n;
  endfunction

endpackage

// File: rtl/checker_salida.sv
// Per-output checker: turns a pop into a valid word one cycle later and compares
// it against the expected header/payload sequence for output I.
module checker_salida
  import gen_trafico_pkg::*;
#(
  parameter int DATA_W = 6,
  parameter int HDR_W  = 2,
  parameter int I      = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     mode,
  input  logic [DATA_W-HDR_W-1:0]  step,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        data,
  output logic                     valid,
  output logic                     mismatch
);

  localparam int PW = DATA_W - HDR_W;

  logic          pop_q;
  logic [PW-1:0] exp_val;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pop_q   <= 1'b0;
      exp_val <= '0;
    end else if (clr) begin
      pop_q   <= 1'b0;
      exp_val <= (mode == MODE_RR) ? PW'(I) : '0;
    end else begin
      pop_q <= pop;
      if (valid) exp_val <= exp_val + step;
    end
  end

  assign valid    = pop_q & en;
  assign mismatch = valid && ((data[DATA_W-1 -: HDR_W] != HDR_W'(I)) ||
                              (data[PW-1:0] != exp_val));

endmodule

// File: rtl/generador_trafico.sv
// Traffic generator and self-checker for the interconnect device.
// Define GEN_CHECKER_EN to build the per-output comparators and err_count.
module generador_trafico
  import gen_trafico_pkg::*;
#(
  parameter int DATA_W  = 6,
  parameter int HDR_W   = 2,
  parameter int N_OUT   = 2,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    mode,
  input  logic [HDR_W-1:0]        class_sel,
  input  logic [CNT_W-1:0]        burst_len,
  input  logic                    MAIN_FIFO_pause,
  input  logic [N_OUT-1:0]        next_pop,
  input  logic [N_OUT*DATA_W-1:0] data_out,
  output logic                    init,
  output logic [DATA_W-1:0]       data_in,
  output logic                    push_data_in,
  output logic [N_OUT-1:0]        pop,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout,
  output logic [ERR_CNT_W-1:0]    err_count
);

  localparam int PW     = DATA_W - HDR_W;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  state_t               state, state_nx;
  logic                 mode_q;
  logic [HDR_W-1:0]     class_q, hdr;
  logic [CNT_W-1:0]     burst_q, sent_cnt, recv_cnt;
  logic [PW-1:0]        payload;
  logic [IDLE_W-1:0]    idle_cnt;
  logic                 pause_q, timeout_q;
  logic [N_OUT-1:0]     valid;
  logic [ERR_CNT_W-1:0] err_q;
  logic                 clr, active, any_valid, last_push, drain_full, drain_expire;

  assign clr          = (state == CONFIG);
  assign active       = (state == SEND) || (state == DRAIN);
  assign any_valid    = |valid;
  assign push_data_in = (state == SEND) && !pause_q;
  assign last_push    = push_data_in && (sent_cnt + CNT_W'(1) == burst_q);
  assign drain_full   = (recv_cnt == burst_q);
  assign drain_expire = !any_valid && (idle_cnt == IDLE_W'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: if (start) state_nx = CONFIG;
      CONFIG:     state_nx = (burst_q == '0) ? DONE : SEND;
      SEND:       if (last_push) state_nx = DRAIN;
      DRAIN:      if (drain_full || drain_expire) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  // Run parameters are captured as the FSM enters CONFIG so CONFIG itself sees them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      mode_q  <= MODE_FIXED;
      class_q <= '0;
      burst_q <= '0;
    end else begin
      state <= state_nx;
      if ((state == IDLE || state == DONE) && start) begin
        mode_q  <= mode;
        class_q <= class_sel;
        burst_q <= burst_len;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      payload   <= '0;
      hdr       <= '0;
      sent_cnt  <= '0;
      recv_cnt  <= '0;
      idle_cnt  <= '0;
      pause_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      pause_q <= MAIN_FIFO_pause;
      if (clr) begin
        payload   <= '0;
        hdr       <= (mode_q == MODE_RR) ? '0 : class_q;
        sent_cnt  <= '0;
        recv_cnt  <= '0;
        idle_cnt  <= '0;
        timeout_q <= 1'b0;
      end else begin
        if (push_data_in) begin
          payload  <= payload + PW'(1);
          sent_cnt <= sent_cnt + CNT_W'(1);
          if (mode_q == MODE_RR)
            hdr <= (hdr == HDR_W'(N_OUT - 1)) ? '0 : hdr + HDR_W'(1);
        end
        recv_cnt <= recv_cnt + CNT_W'(count_ones(32'(valid)));
        if (state == DRAIN) idle_cnt <= any_valid ? '0 : idle_cnt + IDLE_W'(1);
        if (state == DRAIN && !drain_full && drain_expire) timeout_q <= 1'b1;
      end
    end
  end

`ifdef GEN_CHECKER_EN
  logic [N_OUT-1:0]   mismatch;
  logic [PW-1:0]      step;
  logic [ERR_CNT_W:0] err_sum;

  assign step = (mode_q == MODE_RR) ? PW'(N_OUT) : PW'(1);

  for (genvar g = 0; g < N_OUT; g++) begin : g_chk
    checker_salida #(
      .DATA_W (DATA_W),
      .HDR_W  (HDR_W),
      .I      (g)
    ) u_chk (
      .clk      (clk),
      .reset    (reset),
      .clr      (clr),
      .en       (active),
      .mode     (mode_q),
      .step     (step),
      .pop      (pop[g]),
      .data     (data_out[g*DATA_W +: DATA_W]),
      .valid    (valid[g]),
      .mismatch (mismatch[g])
    );
  end

  assign err_sum = {1'b0, err_q} + (ERR_CNT_W + 1)'(count_ones(32'(mismatch)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   err_q <= '0;
    else if (clr) err_q <= '0;
    else          err_q <= err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
  end
`else
  logic [N_OUT-1:0] pop_q;
  logic             unused_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   pop_q <= '0;
    else if (clr) pop_q <= '0;
    else          pop_q <= pop;
  end

  assign valid       = pop_q & {N_OUT{active}};
  assign err_q       = '0;
  assign unused_data = ^data_out;
`endif

  assign init      = clr;
  assign done      = (state == DONE);
  assign pop       = active ? next_pop : '0;
  assign data_in   = (state == SEND) ? {hdr, payload} : '0;
  assign timeout   = timeout_q;
  assign err_count = err_q;
  assign pass      = done && (err_q == '0) && !timeout_q;

endmodule

// File: tb/tb_generador_trafico.sv
// Bench for generador_trafico: ideal two-output FIFO model plus scoreboards for
// pushed words and returned words, driven by a linear sequence of directed runs.
module tb_generador_trafico;

  logic        clk;
  logic        reset;
  logic        start;
  logic        mode;
  logic [1:0]  class_sel;
  logic [15:0] burst_len;
  logic        MAIN_FIFO_pause;
  logic [1:0]  next_pop;
  logic [11:0] data_out;
  logic        init;
  logic [5:0]  data_in;
  logic        push_data_in;
  logic [1:0]  pop;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [7:0]  err_count;

  int checks   = 0;
  int failures = 0;

  logic [5:0] exp_in[$];
  logic [5:0] exp_o0[$];
  logic [5:0] exp_o1[$];
  logic [5:0] q0[$];
  logic [5:0] q1[$];
  bit         chk_out = 1'b1;
  bit         drop    = 1'b0;
  bit         corrupt = 1'b0;
  logic [1:0] pend;
  logic [5:0] w;
  int         d0_cnt;

  generador_trafico #(
    .DATA_W  (6),
    .HDR_W   (2),
    .N_OUT   (2),
    .CNT_W   (16),
    .TIMEOUT (64)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .mode            (mode),
    .class_sel       (class_sel),
    .burst_len       (burst_len),
    .MAIN_FIFO_pause (MAIN_FIFO_pause),
    .next_pop        (next_pop),
    .data_out        (data_out),
    .init            (init),
    .data_in         (data_in),
    .push_data_in    (push_data_in),
    .pop             (pop),
    .done            (done),
    .pass            (pass),
    .timeout         (timeout),
    .err_count       (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Ideal FIFOs: routed by header on push, data_out registered on pop.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q0.delete();
      q1.delete();
      next_pop <= '0;
      data_out <= '0;
      d0_cnt = 0;
    end else begin
      if (init) d0_cnt = 0;
      if (pop[0] && q0.size() != 0) begin
        w = q0.pop_front();
        d0_cnt++;
        if (corrupt && d0_cnt == 3) w = w ^ 6'h01;
        data_out[5:0] <= w;
      end
      if (pop[1] && q1.size() != 0) begin
        w = q1.pop_front();
        data_out[11:6] <= w;
      end
      if (push_data_in && !drop) begin
        if (data_in[5:4] == 2'd0) q0.push_back(data_in);
        else if (data_in[5:4] == 2'd1) q1.push_back(data_in);
      end
      next_pop <= {q1.size() != 0, q0.size() != 0};
    end
  end

  always @(negedge clk) begin
    logic [5:0] e;
    if (!reset) begin
      pend = '0;
    end else begin
      if (push_data_in) begin
        if (exp_in.size() == 0) check("data_in_unexpected", 1, 0);
        else begin
          e = exp_in.pop_front();
          check("data_in", data_in, e);
        end
      end
      if (chk_out && pend[0]) begin
        if (exp_o0.size() == 0) check("d0_unexpected", 1, 0);
        else begin
          e = exp_o0.pop_front();
          check("d0_word", data_out[5:0], e);
        end
      end
      if (chk_out && pend[1]) begin
        if (exp_o1.size() == 0) check("d1_unexpected", 1, 0);
        else begin
          e = exp_o1.pop_front();
          check("d1_word", data_out[11:6], e);
        end
      end
      pend = pop;
    end
  end

  task automatic load_exp(input logic m, input logic [1:0] cls, input int blen, input bit outs);
    for (int k = 0; k < blen; k++) begin
      logic [1:0] h;
      logic [5:0] x;
      h = m ? 2'(k % 2) : cls;
      x = {h, 4'(k % 16)};
      exp_in.push_back(x);
      if (outs) begin
        if (h == 2'd0) exp_o0.push_back(x);
        else exp_o1.push_back(x);
      end
    end
  endtask

  task automatic run(input string tag, input logic m, input logic [1:0] cls, input int blen,
                     input int p_at, input int p_len, input logic exp_pass,
                     input int exp_err, input logic exp_to);
    int c, last_c, n_push, n_low, n_init;
    bit got;
    load_exp(m, cls, blen, chk_out);
    mode      = m;
    class_sel = cls;
    burst_len = 16'(blen);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_init_pulse"}, init, 1);
    check({tag, "_no_push_config"}, push_data_in, 0);
    c = 0; last_c = -1; n_push = 0; n_low = 0; n_init = 0; got = 0;
    while (c < 400 && !got) begin
      MAIN_FIFO_pause = (c >= p_at) && (c < p_at + p_len);
      @(negedge clk);
      c++;
      if (c == 1) check({tag, "_first_push"}, push_data_in, (blen != 0));
      if (init) n_init++;
      if (push_data_in) begin
        n_push++;
        last_c = c;
      end else if (n_push > 0 && n_push < blen) begin
        n_low++;
      end
      if (done) got = 1;
    end
    MAIN_FIFO_pause = 1'b0;
    check({tag, "_done_seen"}, got, 1);
    check({tag, "_pass"}, pass, exp_pass);
    check({tag, "_err_count"}, err_count, exp_err);
    check({tag, "_timeout"}, timeout, exp_to);
    check({tag, "_push_count"}, n_push, blen);
    check({tag, "_push_low"}, n_low, p_len);
    check({tag, "_init_extra"}, n_init, 0);
    check({tag, "_in_left"}, exp_in.size(), 0);
    if (chk_out) check({tag, "_out_left"}, exp_o0.size() + exp_o1.size(), 0);
    if (exp_to) check({tag, "_timeout_delay"}, c - last_c, 65);
    exp_in.delete();
    exp_o0.delete();
    exp_o1.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b0;
    start           = 1'b0;
    mode            = 1'b0;
    class_sel       = 2'd0;
    burst_len       = 16'd0;
    MAIN_FIFO_pause = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_init", init, 0);
    check("rst_push", push_data_in, 0);
    check("rst_data_in", data_in, 0);
    check("rst_pop", pop, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    reset = 1'b1;
    @(negedge clk);

    run("fixed8",  1'b0, 2'd0, 8,  1000, 0, 1'b1, 0, 1'b0);
    run("rr6",     1'b1, 2'd0, 6,  1000, 0, 1'b1, 0, 1'b0);
    run("wrap20",  1'b0, 2'd0, 20, 1000, 0, 1'b1, 0, 1'b0);
    run("fixed_c1",1'b0, 2'd1, 5,  1000, 0, 1'b1, 0, 1'b0);
    run("pause",   1'b0, 2'd0, 8,  3,    3, 1'b1, 0, 1'b0);
    run("zero",    1'b0, 2'd0, 0,  1000, 0, 1'b1, 0, 1'b0);

    chk_out = 1'b0;
    corrupt = 1'b1;
`ifdef GEN_CHECKER_EN
    run("corrupt", 1'b0, 2'd0, 8, 1000, 0, 1'b0, 1, 1'b0);
`else
    run("corrupt", 1'b0, 2'd0, 8, 1000, 0, 1'b1, 0, 1'b0);
`endif
    corrupt = 1'b0;
    drop    = 1'b1;
    run("silent",  1'b0, 2'd0, 8, 1000, 0, 1'b0, 0, 1'b1);
    drop    = 1'b0;

    load_exp(1'b0, 2'd0, 20, 1'b0);
    mode      = 1'b0;
    class_sel = 2'd0;
    burst_len = 16'd20;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_send_push", push_data_in, 1);
    reset = 1'b0;
    #1;
    check("midrst_init", init, 0);
    check("midrst_push", push_data_in, 0);
    check("midrst_data_in", data_in, 0);
    check("midrst_pop", pop, 0);
    check("midrst_done", done, 0);
    check("midrst_pass", pass, 0);
    check("midrst_timeout", timeout, 0);
    check("midrst_err", err_count, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_in.delete();
    @(negedge clk);
    chk_out = 1'b1;
    run("after_rst", 1'b0, 2'd0, 8, 1000, 0, 1'b1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
